// File: rtl/single_pe_conv_scheduler.sv
// Address/enable sequencer for the single-PE 3x3-over-4x4 convolution.
// Computes C11..C22 in turn: clear, nine MAC feeds, PE drain, result write.
module single_pe_conv_scheduler #(
   parameter int unsigned PE_LATENCY = 2
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       start,
   output logic [4:0] input_addr,
   output logic [4:0] filter_addr,
   output logic       mac_en,
   output logic       acc_clr,
   output logic [3:0] buf_we,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StWrite, StDone} state_e;

   localparam logic [2:0] DrainLast = (PE_LATENCY == 0) ? 3'd0 : 3'(PE_LATENCY - 1);
   localparam logic [4:0] ZeroAddr  = 5'd16;

   state_e     state_q, state_d;
   logic [3:0] k_q, k_d;
   logic [1:0] idx_q, idx_d;
   logic [2:0] drain_q, drain_d;
   logic       start_q;
   logic       launch;

   logic [1:0] kr, kc, row, col;
   logic [4:0] input_addr_d, filter_addr_d;
   logic       mac_en_d, acc_clr_d, busy_d, done_d;
   logic [3:0] buf_we_d;

   assign launch = start & ~start_q & (state_q == StIdle);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      case (state_q)
         StIdle: begin
            if (launch) begin
               idx_d   = 2'd0;
               state_d = StClear;
            end
         end
         StClear: begin
            k_d     = 4'd0;
            state_d = StFeed;
         end
         StFeed: begin
            if (k_q == 4'd8) begin
               drain_d = 3'd0;
               state_d = (PE_LATENCY == 0) ? StWrite : StDrain;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         StDrain: begin
            if (drain_q == DrainLast) state_d = StWrite;
            else                      drain_d = drain_q + 3'd1;
         end
         StWrite: begin
            if (idx_q != 2'd3) begin
               idx_d   = idx_q + 2'd1;
               state_d = StClear;
            end else begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from next-state values so they can be registered
   // and still line up with the state they describe.
   always_comb begin
      kr = (k_d >= 4'd6) ? 2'd2 : ((k_d >= 4'd3) ? 2'd1 : 2'd0);
      // k - 3*kr taken mod 4 equals k[1:0] + kr, and k%3 never exceeds 2.
      kc  = k_d[1:0] + kr;
      row = kr + {1'b0, idx_d[1]};
      col = kc + {1'b0, idx_d[0]};

      input_addr_d  = ZeroAddr;
      filter_addr_d = ZeroAddr;
      mac_en_d      = 1'b0;
      acc_clr_d     = 1'b0;
      buf_we_d      = 4'b0000;
      busy_d        = (state_d != StIdle);
      done_d        = (state_d == StDone);
      case (state_d)
         StClear: acc_clr_d = 1'b1;
         StFeed: begin
            mac_en_d      = 1'b1;
            filter_addr_d = {1'b0, k_d};
            input_addr_d  = {1'b0, row, col};
         end
         StWrite: buf_we_d = 4'b0001 << idx_d;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= StIdle;
         k_q         <= 4'd0;
         idx_q       <= 2'd0;
         drain_q     <= 3'd0;
         start_q     <= 1'b1;
         input_addr  <= ZeroAddr;
         filter_addr <= ZeroAddr;
         mac_en      <= 1'b0;
         acc_clr     <= 1'b0;
         buf_we      <= 4'b0000;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         idx_q       <= idx_d;
         drain_q     <= drain_d;
         start_q     <= start;
         input_addr  <= input_addr_d;
         filter_addr <= filter_addr_d;
         mac_en      <= mac_en_d;
         acc_clr     <= acc_clr_d;
         buf_we      <= buf_we_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_single_pe_conv_scheduler.sv
// Bench for single_pe_conv_scheduler: PE_LATENCY 2 and 0 instances share stimulus,
// a per-cycle expected-output queue per instance, and a behavioural PE on the latency-2 one.
module tb_single_pe_conv_scheduler;

   logic clk, rstb, start;

   logic [4:0] ia2, fa2, ia0, fa0;
   logic       mac2, clr2, busy2, done2, mac0, clr0, busy0, done0;
   logic [3:0] we2, we0;

   single_pe_conv_scheduler #(.PE_LATENCY(2)) u_dut2 (
      .clk(clk), .rstb(rstb), .start(start),
      .input_addr(ia2), .filter_addr(fa2), .mac_en(mac2), .acc_clr(clr2),
      .buf_we(we2), .busy(busy2), .done(done2)
   );

   single_pe_conv_scheduler #(.PE_LATENCY(0)) u_dut0 (
      .clk(clk), .rstb(rstb), .start(start),
      .input_addr(ia0), .filter_addr(fa0), .mac_en(mac0), .acc_clr(clr0),
      .buf_we(we0), .busy(busy0), .done(done0)
   );

   localparam logic [17:0] IdleV = {5'd16, 5'd16, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

   logic [17:0] pack2, pack0;
   assign pack2 = {ia2, fa2, mac2, clr2, we2, busy2, done2};
   assign pack0 = {ia0, fa0, mac0, clr0, we0, busy0, done0};

   int checks   = 0;
   int failures = 0;

   logic [17:0] q2[$];
   logic [17:0] q0[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE + operand memories: a = 1..16, b = all ones, two-stage output pipe.
   int acc, pipe0, pipe1;
   int buffer [4];
   always @(posedge clk) begin
      if (clr2) acc <= 0;
      else if (mac2) acc <= acc + ((ia2 < 5'd16) ? int'(ia2) + 1 : 0) * ((fa2 < 5'd9) ? 1 : 0);
      pipe0 <= acc;
      pipe1 <= pipe0;
      for (int i = 0; i < 4; i++) if (we2[i]) buffer[i] <= pipe1;
   end

   logic mon_en, seen_c12_2, seen_c12_0;
   always @(posedge clk) begin
      if (mon_en && we2[1]) seen_c12_2 <= 1'b1;
      if (mon_en && we0[1]) seen_c12_0 <= 1'b1;
   end

   // Expected outputs for cycle t after launch, derived from the run timeline.
   function automatic logic [17:0] exp_out(input int t, input int p);
      logic [17:0] e;
      int j, off, k;
      logic [4:0] ia, fa;
      logic [3:0] we;
      e = IdleV;
      if (t >= 1 && t <= 4 * p) begin
         j   = (t - 1) / p;
         off = (t - 1) % p;
         ia  = 5'd16;
         fa  = 5'd16;
         we  = 4'b0000;
         if (off == 0) begin
            e = {ia, fa, 1'b0, 1'b1, we, 1'b1, 1'b0};
         end else if (off <= 9) begin
            k  = off - 1;
            ia = 5'(4 * (j / 2 + k / 3) + (j % 2) + k % 3);
            fa = 5'(k);
            e  = {ia, fa, 1'b1, 1'b0, we, 1'b1, 1'b0};
         end else if (off == p - 1) begin
            we = 4'(1 << j);
            e  = {ia, fa, 1'b0, 1'b0, we, 1'b1, 1'b0};
         end else begin
            e = {ia, fa, 1'b0, 1'b0, we, 1'b1, 1'b0};
         end
      end else if (t == 4 * p + 1) begin
         e = {5'd16, 5'd16, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1};
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_checked(input int n, input int drop_at, input int rise_at,
                              input string tag);
      int dones2, dones0;
      dones2 = 0;
      dones0 = 0;
      start  = 1'b1;
      for (int t = 1; t <= n; t++) begin
         q2.push_back(exp_out(t, 13));
         q0.push_back(exp_out(t, 11));
      end
      for (int t = 1; t <= n; t++) begin
         step();
         chk($sformatf("%s_lat2_c%0d", tag, t), 32'(pack2), 32'(q2.pop_front()));
         chk($sformatf("%s_lat0_c%0d", tag, t), 32'(pack0), 32'(q0.pop_front()));
         dones2 += int'(done2);
         dones0 += int'(done0);
         if (t == drop_at) start = 1'b0;
         if (t == rise_at) start = 1'b1;
      end
      start = 1'b0;
      chk({tag, "_done_count_lat2"}, 32'(dones2), 32'd1);
      chk({tag, "_done_count_lat0"}, 32'(dones0), 32'd1);
   endtask

   initial begin
      rstb       = 1'b0;
      start      = 1'b1;
      mon_en     = 1'b0;
      seen_c12_2 = 1'b0;
      seen_c12_0 = 1'b0;
      acc        = 0;
      step();
      step();
      chk("reset_lat2", 32'(pack2), 32'(IdleV));
      chk("reset_lat0", 32'(pack0), 32'(IdleV));

      // Start still high at reset release must not launch.
      rstb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("no_launch_lat2_%0d", i), 32'(pack2), 32'(IdleV));
         chk($sformatf("no_launch_lat0_%0d", i), 32'(pack0), 32'(IdleV));
      end
      start = 1'b0;
      step();
      step();

      // Full run with start held for the run plus 10 cycles.
      run_checked(63, 0, 0, "hold");
      step();
      chk("buf_c11", 32'(buffer[0]), 32'd54);
      chk("buf_c12", 32'(buffer[1]), 32'd63);
      chk("buf_c21", 32'(buffer[2]), 32'd90);
      chk("buf_c22", 32'(buffer[3]), 32'd99);
      step();

      // Second 0->1 edge mid-run is ignored.
      run_checked(60, 20, 30, "reedge");
      step();
      step();

      // Reset mid-run: C12 must never be written, outputs return to reset values.
      mon_en = 1'b1;
      start  = 1'b1;
      for (int t = 1; t <= 19; t++) begin
         q2.push_back(exp_out(t, 13));
         q0.push_back(exp_out(t, 11));
      end
      for (int t = 1; t <= 19; t++) begin
         step();
         chk($sformatf("abort_lat2_c%0d", t), 32'(pack2), 32'(q2.pop_front()));
         chk($sformatf("abort_lat0_c%0d", t), 32'(pack0), 32'(q0.pop_front()));
      end
      rstb = 1'b0;
      step();
      chk("midreset_lat2", 32'(pack2), 32'(IdleV));
      chk("midreset_lat0", 32'(pack0), 32'(IdleV));
      rstb  = 1'b1;
      start = 1'b0;
      step();
      chk("post_reset_lat2", 32'(pack2), 32'(IdleV));
      chk("post_reset_lat0", 32'(pack0), 32'(IdleV));
      step();
      for (int i = 0; i < 10; i++) step();
      chk("aborted_c12_we_lat2", 32'(seen_c12_2), 32'd0);
      chk("aborted_c12_we_lat0", 32'(seen_c12_0), 32'd0);
      mon_en = 1'b0;

      // Restart after abort begins again from C11.
      run_checked(56, 0, 0, "rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
